// File: rtl/board_io_conditioner.sv
// board_io_conditioner
//   Board-level input conditioner: per-channel synchroniser, debouncer with
//   one-cycle rise/fall pulses, and a free-running heartbeat LED counter.
//   Optional feature macro: BOARD_IO_IRQ_EN adds sticky per-channel change
//   flags (chg_flags), a per-channel clear (irq_clear) and an OR-ed irq.
//   Single clock domain, synchronous active-low reset (rstn).

module board_io_conditioner #(
   parameter int WIDTH           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HB_BITS         = 24
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] sw_in,
`ifdef BOARD_IO_IRQ_EN
   input  logic [WIDTH-1:0] irq_clear,
   output logic [WIDTH-1:0] chg_flags,
   output logic             irq,
`endif
   output logic [WIDTH-1:0] sw_level,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             heartbeat
);

   localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Synchroniser chain: stage 0 samples the pin, last stage feeds the debouncer.
   logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
   logic [WIDTH-1:0]   sync_d [SYNC_STAGES];
   logic [WIDTH-1:0]   sync_s;

   // Debounce state and registered outputs.
   logic [CNT_W-1:0]   cnt_q  [WIDTH];
   logic [CNT_W-1:0]   cnt_d  [WIDTH];
   logic [WIDTH-1:0]   level_q, level_d;
   logic [WIDTH-1:0]   rise_q,  rise_d;
   logic [WIDTH-1:0]   fall_q,  fall_d;

   // Heartbeat counter.
   logic [HB_BITS-1:0] hb_q, hb_d;

   assign sync_s = sync_q[SYNC_STAGES-1];

   // Next-state for the synchroniser chain: shift pins in one stage per edge.
   always_comb begin
      sync_d[0] = sw_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   // Per-channel debounce: accept a new level once it has differed for
   // DEBOUNCE_CYCLES consecutive edges, pulsing rise/fall on that same edge.
   always_comb begin
      // NOTE: every combinational output gets a default first so that no path
      // through the loop leaves a value unassigned and infers a latch.
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (sync_s[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            cnt_d[i]   = '0;
            level_d[i] = sync_s[i];
            rise_d[i]  = sync_s[i];
            fall_d[i]  = ~sync_s[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Free-running heartbeat count, wrapping from all-ones to zero.
   always_comb begin
      hb_d = hb_q + HB_BITS'(1);
   end

   // State registers; reset clears every flop so a reset mid-debounce
   // discards the count and never manufactures an edge pulse.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      if (!rstn) begin
         // NOTE: the sync chain and counters are small flop arrays, not RAM,
         // so they are reset explicitly like any other register.
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
         level_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         hb_q    <= '0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         hb_q    <= hb_d;
      end
   end

   assign sw_level  = level_q;
   assign sw_rise   = rise_q;
   assign sw_fall   = fall_q;
   assign heartbeat = hb_q[HB_BITS-1];

`ifdef BOARD_IO_IRQ_EN
   logic [WIDTH-1:0] chg_q, chg_d;

   // Sticky change flags: set by a visible pulse, cleared by irq_clear;
   // a set on the same edge as a clear wins.
   always_comb begin
      chg_d = (chg_q & ~irq_clear) | rise_q | fall_q;
   end

   // Change-flag register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         chg_q <= '0;
      end else begin
         chg_q <= chg_d;
      end
   end

   assign chg_flags = chg_q;
   assign irq       = |chg_q;
`endif

endmodule

// File: tb/tb_board_io_conditioner.sv
// tb_board_io_conditioner
//   Scoreboard bench for board_io_conditioner (HB_BITS reduced to 4 so the
//   heartbeat wraps often). The driver applies stimulus, advances a
//   history-based reference model and queues the expected outputs; a monitor
//   on the falling edge pops and compares. Honours BOARD_IO_IRQ_EN.

module tb_board_io_conditioner;

   localparam int WIDTH = 4;
   localparam int SS    = 2;
   localparam int DB    = 4;
   localparam int HB    = 4;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic [WIDTH-1:0] sw_in = '0;
   logic [WIDTH-1:0] sw_level, sw_rise, sw_fall;
   logic             heartbeat;
`ifdef BOARD_IO_IRQ_EN
   logic [WIDTH-1:0] irq_clear = '0;
   logic [WIDTH-1:0] chg_flags;
   logic             irq;
`endif

   board_io_conditioner #(
      .WIDTH(WIDTH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .HB_BITS(HB)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .sw_in     (sw_in),
`ifdef BOARD_IO_IRQ_EN
      .irq_clear (irq_clear),
      .chg_flags (chg_flags),
      .irq       (irq),
`endif
      .sw_level  (sw_level),
      .sw_rise   (sw_rise),
      .sw_fall   (sw_fall),
      .heartbeat (heartbeat)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] level;
      logic [WIDTH-1:0] rise;
      logic [WIDTH-1:0] fall;
      logic [WIDTH-1:0] chg;
      logic             hb;
      logic             irq;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: raw samples and synced values since reset release.
   int               m_k = 0;
   logic [WIDTH-1:0] m_samp[$];
   logic [WIDTH-1:0] m_sync[$];
   logic [WIDTH-1:0] m_level = '0;
   logic [WIDTH-1:0] m_rise  = '0;
   logic [WIDTH-1:0] m_fall  = '0;
   logic [WIDTH-1:0] m_chg   = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model by one clock edge with the inputs present at that edge.
   // A channel flips when its synced value disagreed with the level on each of
   // the last DB edges since release; the synced value seen at edge k is the
   // pin sampled at edge k-SS.
   task automatic model_edge(input logic r, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
      exp_t             e;
      logic [WIDTH-1:0] prev_pulse;
      logic [WIDTH-1:0] synced;
      bit               differs;
      if (!r) begin
         m_k = 0;
         m_samp.delete();
         m_sync.delete();
         m_level = '0;
         m_rise  = '0;
         m_fall  = '0;
         m_chg   = '0;
      end else begin
         prev_pulse = m_rise | m_fall;
         m_k++;
         m_samp.push_back(s);
         synced = (m_k > SS) ? m_samp[m_k-SS-1] : '0;
         m_sync.push_back(synced);
         m_rise = '0;
         m_fall = '0;
         for (int i = 0; i < WIDTH; i++) begin
            if (m_k >= DB) begin
               differs = 1'b1;
               for (int j = m_k - DB; j < m_k; j++) begin
                  if (m_sync[j][i] == m_level[i]) differs = 1'b0;
               end
               if (differs) begin
                  m_level[i] = ~m_level[i];
                  if (m_level[i]) m_rise[i] = 1'b1;
                  else            m_fall[i] = 1'b1;
               end
            end
         end
         m_chg = (m_chg & ~c) | prev_pulse;
      end
      e.level = m_level;
      e.rise  = m_rise;
      e.fall  = m_fall;
      e.chg   = m_chg;
      e.hb    = ((m_k % (1 << HB)) >= (1 << (HB - 1)));
      e.irq   = |m_chg;
      exp_q.push_back(e);
   endtask

   // Drive one cycle of inputs, let the edge happen, record the expectation.
   task automatic step(input logic r, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
      rstn  = r;
      sw_in = s;
`ifdef BOARD_IO_IRQ_EN
      irq_clear = c;
`endif
      @(posedge clk);
      model_edge(r, s, c);
      #1;
   endtask

   task automatic hold(input int n, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
      for (int i = 0; i < n; i++) step(1'b1, s, c);
   endtask

   // Monitor: compare the DUT against the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("sw_level",  32'(sw_level),  32'(e.level));
         check("sw_rise",   32'(sw_rise),   32'(e.rise));
         check("sw_fall",   32'(sw_fall),   32'(e.fall));
         check("heartbeat", 32'(heartbeat), 32'(e.hb));
         check("rise_fall_exclusive", 32'(sw_rise & sw_fall), 32'(0));
`ifdef BOARD_IO_IRQ_EN
         check("chg_flags", 32'(chg_flags), 32'(e.chg));
         check("irq",       32'(irq),       32'(e.irq));
`endif
      end
   end

   initial begin
      logic [WIDTH-1:0] rnd_sw;
      int               hold_left [WIDTH];

      // Reset with all pins high, then release: level F accepted after edge 6.
      for (int i = 0; i < 3; i++) step(1'b0, 4'hF, 4'h0);
      hold(10, 4'hF, 4'h0);
      hold(10, 4'h0, 4'h0);

      // Clean single-channel rise, then glitches on channel 1.
      hold(10, 4'b0001, 4'h0);
      hold(3,  4'b0011, 4'h0);
      hold(10, 4'b0001, 4'h0);
      hold(4,  4'b0011, 4'h0);
      hold(12, 4'b0001, 4'h0);

      // Simultaneous multi-channel edges.
      hold(10, 4'b0000, 4'h0);
      hold(10, 4'b0101, 4'h0);
      hold(10, 4'b1010, 4'h0);

      // Reset mid heartbeat period and mid debounce.
      hold(5, 4'b0101, 4'h0);
      step(1'b0, 4'b0101, 4'h0);
      step(1'b0, 4'b0101, 4'h0);
      hold(20, 4'b0101, 4'h0);

      // Change flags: rise on ch2, clear coinciding with a new fall, clear alone.
      hold(10, 4'b0000, 4'h0);
      hold(10, 4'b0100, 4'h0);
      hold(10, 4'b0000, 4'b0100);
      hold(5,  4'b0000, 4'h0);

      // Randomised phase: per-channel random hold lengths straddling DB,
      // occasional clears and rare resets.
      rnd_sw = '0;
      for (int i = 0; i < WIDTH; i++) hold_left[i] = 0;
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (hold_left[i] == 0) begin
               rnd_sw[i]    = 1'($urandom_range(0, 1));
               hold_left[i] = int'($urandom_range(1, 2 * DB + 2));
            end
            hold_left[i]--;
         end
         step(($urandom_range(0, 299) != 0), rnd_sw,
              ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
      end

      @(negedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
